param_fifo: RTL and testbench
=============================

Name: param_fifo

Overview:
Parametrised synchronous FIFO; next generation of the CPU's byte FIFO (UART/IO buffering).
- Generalised data width and depth; uses the full DEPTH capacity.
- Adds occupancy count, almost-full/almost-empty thresholds, sticky overflow/underflow flags, synchronous flush and asynchronous reset.
- Single clock domain; sits between IO peripherals and the memory-mapped CPU bus.

Parameters:
WIDTH, 8, data word width in bits
DEPTH_LOG2, 8, log2 of entry count; DEPTH = 2**DEPTH_LOG2
AF_LEVEL, DEPTH-4, AF asserts when COUNT >= AF_LEVEL
AE_LEVEL, 4, AE asserts when COUNT <= AE_LEVEL

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous active-high reset
FLUSH  in  1  synchronous clear of contents and sticky flags
DIN  in  WIDTH  write data
WE  in  1  write request
RREQ  in  1  read request
DO  out  WIDTH  read data
FF  out  1  full (COUNT == DEPTH)
FE  out  1  empty (COUNT == 0)
AF  out  1  almost full
AE  out  1  almost empty
COUNT  out  DEPTH_LOG2+1  current occupancy
OVF  out  1  sticky: write attempted while full and not accepted
UDF  out  1  sticky: read attempted while empty

Behaviour:
- Reset (RST high, async): read and write pointers = 0, DO = 0, COUNT = 0, FE = 1, AE = 1, FF = 0, AF = 0, OVF = 0, UDF = 0. Storage array is not reset. Reset mid-transfer discards all contents.
- Pointers are DEPTH_LOG2+1 bits wide; the MSB distinguishes full from empty. COUNT = wp - rp, modulo 2**(DEPTH_LOG2+1). All DEPTH entries are usable.
- FF, FE, AF, AE and COUNT are registered-state derived and combinational from the pointers, so they update the cycle after the causing edge.
- Write: WE && (!FF || read accepted this cycle) -> mem[wp] <= DIN; wp increments. Otherwise the write is dropped and OVF <= 1.
- Read (default mode): RREQ && !FE -> DO <= mem[rp]; rp increments. Latency is 1 cycle, and DO holds its value until the next accepted read. RREQ && FE -> DO unchanged, rp unchanged, UDF <= 1.
- Simultaneous WE and RREQ:
  - Not full, not empty: both accepted; COUNT unchanged.
  - Full: both accepted; the read frees the slot, so no OVF.
  - Empty (default mode): write accepted, read rejected with UDF set; no same-cycle bypass.
- Pointer wrap: natural modulo wrap at 2**(DEPTH_LOG2+1). There is no special case.
- FLUSH (sync): takes priority over WE and RREQ in that cycle. Pointers = 0, OVF = UDF = 0, DO unchanged.
- OVF and UDF clear only on RST or FLUSH.

Optional Feature:
FIFO_FWFT_EN
- Defined: first-word-fall-through. DO always presents mem[rp] (valid when !FE). RREQ acts as an acknowledge that pops the head; the next head appears on DO the following cycle. Read from empty sets UDF. Write into an empty FIFO becomes visible on DO one cycle after the write edge.
- Undefined: standard mode as in Behaviour (registered DO, 1-cycle latency).

Decomposition:
- Shared include fifo_defs.vh: default WIDTH/DEPTH_LOG2 constants and a clog2 helper macro. It is reused by the UART TX/RX instances.
- Natural sub-module: fifo_ram, a simple dual-port array (1 write port, 1 synchronous read port, plus a combinational read port for FWFT).
- Pointer/flag logic stays in param_fifo.

Test Plan:
1. Reset then idle, WIDTH=8, DEPTH_LOG2=4 -> FE=1, AE=1, COUNT=0, DO=0x00, OVF=UDF=0.
2. Write 0x01..0x10 (16 words), then one more write of 0xAA -> FF=1 after 16th, COUNT=16, OVF=1, 0xAA not stored; AF asserts at COUNT=12.
3. From full, read 16 times -> DO sequence 0x01..0x10, each 1 cycle after RREQ; FE=1 at end; 17th RREQ -> DO stays 0x10, UDF=1.
4. Stream 40 words with WE and RREQ both high each cycle after 1 prefill -> COUNT stays 1, data order preserved across pointer wrap, no OVF/UDF.
5. Full FIFO with WE=RREQ=1 same cycle -> write accepted, COUNT stays 16, OVF=0; then FLUSH with WE=1 -> COUNT=0, FE=1, OVF=UDF=0, write ignored.
6. Assert RST asynchronously mid-write of 5 words -> all outputs take reset values immediately (before the next CLK edge). With FIFO_FWFT_EN: write 0x5A into empty -> DO=0x5A next cycle without RREQ.

Source files
------------

// File: rtl/param_fifo_pkg.sv
// rtl/param_fifo_pkg.sv - shared defaults, status struct and sizing helper for param_fifo
package param_fifo_pkg;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_DEPTH_LOG2 = 8;

  typedef struct packed {
    logic ff;
    logic fe;
    logic af;
    logic ae;
  } fifo_status_t;

  function automatic int depth_of(input int log2);
    return 1 << log2;
  endfunction

endpackage

// File: rtl/param_fifo_if.sv
// rtl/param_fifo_if.sv - data/flag bundle between the FIFO and its user
interface param_fifo_if
  import param_fifo_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
);
  logic                  FLUSH;
  logic [WIDTH-1:0]      DIN;
  logic                  WE;
  logic                  RREQ;
  logic [WIDTH-1:0]      DO;
  logic                  FF;
  logic                  FE;
  logic                  AF;
  logic                  AE;
  logic [DEPTH_LOG2:0]   COUNT;
  logic                  OVF;
  logic                  UDF;

  modport master (
    output FLUSH, DIN, WE, RREQ,
    input  DO, FF, FE, AF, AE, COUNT, OVF, UDF
  );

  modport slave (
    input  FLUSH, DIN, WE, RREQ,
    output DO, FF, FE, AF, AE, COUNT, OVF, UDF
  );
endinterface

// File: rtl/param_fifo_ram.sv
// rtl/param_fifo_ram.sv - fifo_ram: 1 write port, registered read port and a look-ahead read port
module fifo_ram
  import param_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = DEF_DEPTH_LOG2,
  parameter bit FWFT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [depth_of(AW)];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the output register is reset; the array contents are don't-care after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata_q <= '0;
    else if (re) rdata_q <= mem[raddr];
  end

  assign rdata = FWFT ? mem[raddr] : rdata_q;
endmodule

// File: rtl/param_fifo.sv
// rtl/param_fifo.sv - parametrised synchronous FIFO with occupancy, thresholds and sticky error flags
// Optional first-word-fall-through read mode selected by FIFO_FWFT_EN.
module param_fifo
  import param_fifo_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int AF_LEVEL   = depth_of(DEPTH_LOG2) - 4,
  parameter int AE_LEVEL   = 4
) (
  input  logic         CLK,
  input  logic         RST,
  param_fifo_if.slave  bus
);
  localparam int AW = DEPTH_LOG2;
  localparam logic [AW:0] FULL_C = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] AF_L   = AF_LEVEL[AW:0];
  localparam logic [AW:0] AE_L   = AE_LEVEL[AW:0];
`ifdef FIFO_FWFT_EN
  localparam bit FWFT = 1'b1;
`else
  localparam bit FWFT = 1'b0;
`endif

  logic [AW:0]      wp, rp, count;
  logic             ovf, udf;
  logic             rd_acc, wr_acc;
  logic [WIDTH-1:0] rdata;
  fifo_status_t     st;

  // Extra pointer bit separates full from empty, so all DEPTH slots are usable.
  assign count = wp - rp;

  always_comb begin
    st    = '0;
    st.ff = (count == FULL_C);
    st.fe = (count == '0);
    st.af = (count >= AF_L);
    st.ae = (count <= AE_L);
  end

  assign rd_acc = bus.RREQ && !st.fe && !bus.FLUSH;
  assign wr_acc = bus.WE && (!st.ff || rd_acc) && !bus.FLUSH;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wp  <= '0;
      rp  <= '0;
      ovf <= 1'b0;
      udf <= 1'b0;
    end else if (bus.FLUSH) begin
      wp  <= '0;
      rp  <= '0;
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (wr_acc)                wp  <= wp + 1'b1;
      if (rd_acc)                rp  <= rp + 1'b1;
      if (bus.WE && !wr_acc)     ovf <= 1'b1;
      if (bus.RREQ && st.fe)     udf <= 1'b1;
    end
  end

  fifo_ram #(
    .WIDTH (WIDTH),
    .AW    (AW),
    .FWFT  (FWFT)
  ) u_ram (
    .clk   (CLK),
    .rst   (RST),
    .we    (wr_acc),
    .waddr (wp[AW-1:0]),
    .wdata (bus.DIN),
    .re    (rd_acc),
    .raddr (rp[AW-1:0]),
    .rdata (rdata)
  );

  // In look-ahead mode an empty FIFO presents zero rather than stale array data.
  assign bus.DO    = (FWFT && st.fe) ? '0 : rdata;
  assign bus.FF    = st.ff;
  assign bus.FE    = st.fe;
  assign bus.AF    = st.af;
  assign bus.AE    = st.ae;
  assign bus.COUNT = count;
  assign bus.OVF   = ovf;
  assign bus.UDF   = udf;
endmodule

// File: tb/tb_param_fifo.sv
// tb/tb_param_fifo.sv - self-checking bench for param_fifo against a queue reference model
module tb_param_fifo;
  localparam int W   = 8;
  localparam int DL2 = 4;
  localparam int DEP = 16;
  localparam int AFL = 12;
  localparam int AEL = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  param_fifo_if #(.WIDTH(W), .DEPTH_LOG2(DL2)) bus ();

  param_fifo #(.WIDTH(W), .DEPTH_LOG2(DL2), .AF_LEVEL(AFL), .AE_LEVEL(AEL)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_total = 0;
  int n_pass  = 0;
  int step    = 0;

  logic [W-1:0] q[$];
  logic [W-1:0] m_do;
  logic         m_ovf, m_udf;

  typedef struct {
    logic         we, rr, fl;
    logic [W-1:0] din;
    int           exp_count;
    logic         exp_ovf, exp_udf;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step=%0d got=%0h expected=%0h", nm, step, act, exp);
  endtask

  function automatic void model_reset();
    q.delete();
    m_do  = '0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endfunction

  function automatic void model_step(input logic we, rr, fl, input logic [W-1:0] din);
    logic rd, wr;
    if (fl) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      return;
    end
    rd = rr && (q.size() > 0);
    wr = we && ((q.size() < DEP) || rd);
    if (rr && !rd) m_udf = 1'b1;
    if (we && !wr) m_ovf = 1'b1;
    if (rd) m_do = q.pop_front();
    if (wr) q.push_back(din);
  endfunction

  function automatic logic [W-1:0] exp_do();
`ifdef FIFO_FWFT_EN
    return (q.size() > 0) ? q[0] : '0;
`else
    return m_do;
`endif
  endfunction

  task automatic compare_all();
    check("COUNT", bus.COUNT, q.size());
    check("FF",    bus.FF,    q.size() == DEP);
    check("FE",    bus.FE,    q.size() == 0);
    check("AF",    bus.AF,    q.size() >= AFL);
    check("AE",    bus.AE,    q.size() <= AEL);
    check("DO",    bus.DO,    exp_do());
    check("OVF",   bus.OVF,   m_ovf);
    check("UDF",   bus.UDF,   m_udf);
  endtask

  task automatic cyc(input logic we, rr, fl, input logic [W-1:0] din);
    bus.WE = we; bus.RREQ = rr; bus.FLUSH = fl; bus.DIN = din;
    @(posedge CLK);
    model_step(we, rr, fl, din);
    #1;
    step++;
    compare_all();
    bus.WE = 1'b0; bus.RREQ = 1'b0; bus.FLUSH = 1'b0;
  endtask

  vec_t vt[8];

  initial begin
    bus.WE = 1'b0; bus.RREQ = 1'b0; bus.FLUSH = 1'b0; bus.DIN = '0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    compare_all();
    RST = 1'b0;
    cyc(0, 0, 0, 8'h00);

    // Fill to capacity, then one write too many.
    for (int i = 1; i <= DEP; i++) begin
      cyc(1, 0, 0, W'(i));
      if (i == AFL) check("af_at_12", bus.AF, 1'b1);
      if (i == AFL - 1) check("af_below_12", bus.AF, 1'b0);
    end
    cyc(1, 0, 0, 8'hAA);
    check("ovf_on_full", bus.OVF, 1'b1);

    // Drain and under-read.
    for (int i = 0; i < DEP; i++) cyc(0, 1, 0, 8'h00);
    cyc(0, 1, 0, 8'h00);
    check("udf_on_empty", bus.UDF, 1'b1);

    // Stream across the pointer wrap with occupancy held at one.
    cyc(0, 0, 1, 8'h00);
    cyc(1, 0, 0, 8'h80);
    for (int i = 0; i < 40; i++) cyc(1, 1, 0, W'(8'h81 + i));

    // Table: simultaneous access at full, flush priority, empty corner cases.
    cyc(0, 0, 1, 8'h00);
    for (int i = 0; i < DEP; i++) cyc(1, 0, 0, W'(8'hB0 + i));
    vt[0] = '{1'b1, 1'b1, 1'b0, 8'h77, 16, 1'b0, 1'b0};
    vt[1] = '{1'b1, 1'b0, 1'b1, 8'h99, 0,  1'b0, 1'b0};
    vt[2] = '{1'b0, 1'b1, 1'b0, 8'h00, 0,  1'b0, 1'b1};
    vt[3] = '{1'b1, 1'b0, 1'b0, 8'h33, 1,  1'b0, 1'b1};
    vt[4] = '{1'b1, 1'b1, 1'b0, 8'h44, 1,  1'b0, 1'b1};
    vt[5] = '{1'b0, 1'b0, 1'b1, 8'h00, 0,  1'b0, 1'b0};
    vt[6] = '{1'b1, 1'b1, 1'b0, 8'h55, 1,  1'b0, 1'b1};
    vt[7] = '{1'b0, 1'b1, 1'b0, 8'h00, 0,  1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      cyc(vt[i].we, vt[i].rr, vt[i].fl, vt[i].din);
      check("tbl_count", bus.COUNT, vt[i].exp_count);
      check("tbl_ovf",   bus.OVF,   vt[i].exp_ovf);
      check("tbl_udf",   bus.UDF,   vt[i].exp_udf);
    end

`ifdef FIFO_FWFT_EN
    cyc(0, 0, 1, 8'h00);
    cyc(1, 0, 0, 8'h5A);
    check("fwft_head", bus.DO, 8'h5A);
`endif

    // Asynchronous reset in the middle of a burst of writes.
    cyc(1, 0, 0, 8'hC1);
    cyc(1, 0, 0, 8'hC2);
    cyc(1, 0, 1'b0, 8'hC3);
    bus.WE = 1'b1; bus.DIN = 8'hC4;
    #2 RST = 1'b1;
    #1;
    model_reset();
    step++;
    compare_all();
    bus.WE = 1'b0;
    #2 RST = 1'b0;
    cyc(0, 0, 0, 8'h00);

    // Randomised traffic against the queue model.
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 99) < ((i < 300) ? 60 : 40),
          $urandom_range(0, 99) < ((i < 300) ? 40 : 60),
          $urandom_range(0, 99) < 2,
          W'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
